// File: rtl/keypad_matrix_scanner_pkg.sv
// Shared types and helpers for the keypad matrix scanner and the downstream key decoder.
package keypad_pkg;

    typedef enum logic [1:0] {
        KP_SCAN     = 2'd0,
        KP_DEBOUNCE = 2'd1,
        KP_PRESSED  = 2'd2,
        KP_RELEASE  = 2'd3
    } kp_state_t;

    // Bit position of a one-hot vector; callers only pass single-bit vectors.
    function automatic int unsigned onehot_to_index(input logic [31:0] onehot);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (onehot[i]) idx = i;
        end
        return idx;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/keypad_matrix_scanner_tick.sv
// Scan-rate prescaler: tick is high for one clk cycle out of every SCAN_DIV.
module scan_tick_gen #(
    parameter int SCAN_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    assign tick   = w_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_last ? '0 : r_cnt + ONE;
        end
    end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Row-scan / column-sense keypad controller with press/release debounce and optional auto-repeat.
//  state        | meaning
//  KP_SCAN      | stepping rows, looking for exactly one active column
//  KP_DEBOUNCE  | candidate key seen, counting consecutive matching ticks
//  KP_PRESSED   | key accepted, row frozen, optional auto-repeat running
//  KP_RELEASE   | latched column dropped, counting consecutive released ticks
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SCAN_DIV       = 1,
    parameter int DEBOUNCE_TICKS = 8,
    parameter int RELEASE_TICKS  = 8,
    parameter int REPEAT_TICKS   = 0,
    parameter int ACTIVE_LOW     = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [COLS-1:0]               col,
    output logic [ROWS-1:0]               row_drive,
    output logic [$clog2(ROWS*COLS)-1:0]  key_code,
    output logic                          key_valid,
    output logic                          key_release,
    output logic                          key_held
);

    localparam int KC_W  = $clog2(ROWS * COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);
    localparam int CNT_W = $clog2(max2(DEBOUNCE_TICKS, RELEASE_TICKS) + 1);
    localparam int REP_W = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_TICKS);
    localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_TICKS);
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COLS-1:0]  COL_LSB  = {{(COLS-1){1'b0}}, 1'b1};
    localparam logic [ROWS-1:0]  ROW_LSB  = {{(ROWS-1){1'b0}}, 1'b1};

    kp_state_t        r_state,     w_state_n;
    logic [ROW_W-1:0] r_row_idx,   w_row_n;
    logic [COL_W-1:0] r_col_idx,   w_col_n;
    logic [CNT_W-1:0] r_cnt,       w_cnt_n;
    logic [REP_W-1:0] r_rep_cnt,   w_rep_n;
    logic [KC_W-1:0]  r_key_code,  w_code_n;
    logic             r_key_valid, w_valid_n;
    logic             r_key_rel,   w_release_n;
    logic             r_key_held,  w_held_n;

    logic             w_tick;
    logic [COLS-1:0]  w_col_a;
    logic [ROWS-1:0]  w_row_a;
    logic             w_single;
    logic             w_match;
    logic             w_bit;
    logic [COL_W-1:0] w_col_idx_new;
    logic [ROW_W-1:0] w_row_adv;

    function automatic logic [KC_W-1:0] make_code(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
        return KC_W'(32'(r) * 32'(COLS) + 32'(c));
    endfunction

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    assign w_col_a       = (ACTIVE_LOW != 0) ? ~col : col;
    assign w_row_a       = ROW_LSB << r_row_idx;
    assign row_drive     = (ACTIVE_LOW != 0) ? ~w_row_a : w_row_a;
    // Empty and multi-key columns both read as "no key".
    assign w_single      = (w_col_a != '0) && ((w_col_a & (w_col_a - COL_LSB)) == '0);
    assign w_match       = (w_col_a == (COL_LSB << r_col_idx));
    assign w_bit         = w_col_a[r_col_idx];
    assign w_col_idx_new = COL_W'(onehot_to_index(32'(w_col_a)));
    assign w_row_adv     = (r_row_idx == ROW_LAST) ? '0 : r_row_idx + ROW_ONE;

    assign key_code    = r_key_code;
    assign key_valid   = r_key_valid;
    assign key_release = r_key_rel;
    assign key_held    = r_key_held;

    always_comb begin
        w_state_n   = r_state;
        w_row_n     = r_row_idx;
        w_col_n     = r_col_idx;
        w_cnt_n     = r_cnt;
        w_rep_n     = r_rep_cnt;
        w_code_n    = r_key_code;
        w_valid_n   = 1'b0;
        w_release_n = 1'b0;
        w_held_n    = r_key_held;
        if (w_tick) begin
            unique case (r_state)
                KP_SCAN: begin
                    if (w_single) begin
                        w_col_n = w_col_idx_new;
                        if (DEBOUNCE_TICKS == 1) begin
                            w_state_n = KP_PRESSED;
                            w_cnt_n   = '0;
                            w_code_n  = make_code(r_row_idx, w_col_idx_new);
                            w_valid_n = 1'b1;
                            w_held_n  = 1'b1;
                            w_rep_n   = '0;
                        end else begin
                            w_state_n = KP_DEBOUNCE;
                            w_cnt_n   = CNT_ONE;
                        end
                    end else begin
                        w_row_n = w_row_adv;
                    end
                end
                KP_DEBOUNCE: begin
                    if (w_match) begin
                        if (r_cnt + CNT_ONE == DEB_LAST) begin
                            w_state_n = KP_PRESSED;
                            w_cnt_n   = '0;
                            w_code_n  = make_code(r_row_idx, r_col_idx);
                            w_valid_n = 1'b1;
                            w_held_n  = 1'b1;
                            w_rep_n   = '0;
                        end else begin
                            w_cnt_n = r_cnt + CNT_ONE;
                        end
                    end else begin
                        w_state_n = KP_SCAN;
                        w_cnt_n   = '0;
                        w_row_n   = w_row_adv;
                    end
                end
                KP_PRESSED: begin
                    if (!w_bit) begin
                        if (RELEASE_TICKS == 1) begin
                            w_state_n   = KP_SCAN;
                            w_cnt_n     = '0;
                            w_release_n = 1'b1;
                            w_held_n    = 1'b0;
                            w_row_n     = w_row_adv;
                        end else begin
                            w_state_n = KP_RELEASE;
                            w_cnt_n   = CNT_ONE;
                        end
                    end else if (REPEAT_TICKS > 0) begin
                        if (r_rep_cnt + REP_ONE == REP_LAST) begin
                            w_valid_n = 1'b1;
                            w_rep_n   = '0;
                        end else begin
                            w_rep_n = r_rep_cnt + REP_ONE;
                        end
                    end
                end
                KP_RELEASE: begin
                    if (!w_bit) begin
                        if (r_cnt + CNT_ONE == REL_LAST) begin
                            w_state_n   = KP_SCAN;
                            w_cnt_n     = '0;
                            w_release_n = 1'b1;
                            w_held_n    = 1'b0;
                            w_row_n     = w_row_adv;
                        end else begin
                            w_cnt_n = r_cnt + CNT_ONE;
                        end
                    end else begin
                        // Bounce during release: resume the hold, repeat phase untouched.
                        w_state_n = KP_PRESSED;
                        w_cnt_n   = '0;
                    end
                end
                default: begin
                    w_state_n = KP_SCAN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= KP_SCAN;
            r_row_idx   <= '0;
            r_col_idx   <= '0;
            r_cnt       <= '0;
            r_rep_cnt   <= '0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_rel   <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_row_idx   <= w_row_n;
            r_col_idx   <= w_col_n;
            r_cnt       <= w_cnt_n;
            r_rep_cnt   <= w_rep_n;
            r_key_code  <= w_code_n;
            r_key_valid <= w_valid_n;
            r_key_rel   <= w_release_n;
            r_key_held  <= w_held_n;
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: three instances (plain, auto-repeat, active-low) driven by a key-matrix model.
module tb_keypad_matrix_scanner;

    logic       clk;
    logic       reset;
    logic [3:0] rd  [3];
    logic [3:0] cs  [3];
    logic [3:0] kc  [3];
    logic       kv  [3];
    logic       kr  [3];
    logic       kh  [3];

    logic       key_on  [3];
    int         key_row [3];
    logic [3:0] key_pat [3];

    int n_cmp = 0;
    int n_err = 0;
    int rel_cnt [3];
    int exp_q0 [$];
    int exp_q1 [$];
    int exp_q2 [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    keypad_matrix_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_TICKS(3), .RELEASE_TICKS(2),
                            .REPEAT_TICKS(0), .ACTIVE_LOW(0)) dut_a (
        .clk(clk), .reset(reset), .col(cs[0]), .row_drive(rd[0]), .key_code(kc[0]),
        .key_valid(kv[0]), .key_release(kr[0]), .key_held(kh[0]));

    keypad_matrix_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_TICKS(3), .RELEASE_TICKS(2),
                            .REPEAT_TICKS(5), .ACTIVE_LOW(0)) dut_r (
        .clk(clk), .reset(reset), .col(cs[1]), .row_drive(rd[1]), .key_code(kc[1]),
        .key_valid(kv[1]), .key_release(kr[1]), .key_held(kh[1]));

    keypad_matrix_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_TICKS(3), .RELEASE_TICKS(2),
                            .REPEAT_TICKS(0), .ACTIVE_LOW(1)) dut_l (
        .clk(clk), .reset(reset), .col(cs[2]), .row_drive(rd[2]), .key_code(kc[2]),
        .key_valid(kv[2]), .key_release(kr[2]), .key_held(kh[2]));

    // Key matrix: the pressed pattern appears on the columns only while its row is driven.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            logic [3:0] row_a;
            logic [3:0] col_a;
            row_a = (k == 2) ? ~rd[k] : rd[k];
            col_a = 4'b0000;
            if (key_on[k] && row_a[key_row[k]]) col_a = key_pat[k];
            cs[k] = (k == 2) ? ~col_a : col_a;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic timeout_fail(input string tag);
        n_cmp++;
        n_err++;
        $display("FAIL %s: wait expired, observed no event expected one", tag);
    endtask

    task automatic sb_pop(input int k, input logic [3:0] code);
        int have;
        int e;
        have = 0;
        e    = 0;
        case (k)
            0: if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1; end
            1: if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1; end
            default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); have = 1; end
        endcase
        if (have == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_key_valid dut%0d: observed code %0h expected no strobe", k, code);
        end else begin
            chk($sformatf("key_code_on_valid dut%0d", k), 32'(code), 32'(e));
        end
    endtask

    // Scoreboard side: every key_valid strobe must match the next pushed code.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            for (int k = 0; k < 3; k++) begin
                if (kv[k] === 1'b1) begin
                    sb_pop(k, kc[k]);
                    chk($sformatf("valid_release_exclusive dut%0d", k), 32'(kr[k]), 32'd0);
                end
                if (kr[k] === 1'b1) rel_cnt[k]++;
            end
        end
    end

    task automatic wait_row(input int k, input logic [3:0] pat);
        int n;
        n = 0;
        @(negedge clk);
        while (rd[k] === pat && n < 100) begin @(negedge clk); n++; end
        while (rd[k] !== pat && n < 200) begin @(negedge clk); n++; end
        if (rd[k] !== pat) timeout_fail($sformatf("wait_row dut%0d", k));
    endtask

    task automatic wait_release(input int k);
        int n;
        n = 0;
        while (kr[k] !== 1'b1 && n < 60) begin @(negedge clk); n++; end
        if (kr[k] !== 1'b1) timeout_fail($sformatf("wait_release dut%0d", k));
    endtask

    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            key_on[k]  = 1'b0;
            key_row[k] = 0;
            key_pat[k] = 4'b0000;
            rel_cnt[k] = 0;
        end

        // Reset and idle scan
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_row_a", 32'(rd[0]), 32'h1);
        chk("reset_row_l", 32'(rd[2]), 32'he);
        chk("reset_code", 32'(kc[0]), 32'h0);
        chk("reset_strobes", 32'({kv[0], kr[0], kh[0], kv[1], kr[1], kh[1], kv[2], kr[2], kh[2]}), 32'h0);
        reset = 1'b0;
        clocks(4);  chk("scan_row1", 32'(rd[0]), 32'h2);
        clocks(4);  chk("scan_row2", 32'(rd[0]), 32'h4);
        clocks(4);  chk("scan_row3", 32'(rd[0]), 32'h8);
        clocks(4);  chk("scan_wrap", 32'(rd[0]), 32'h1);
        chk("scan_wrap_l", 32'(rd[2]), 32'he);

        // Multi-key on row 0: treated as no key
        key_row[0] = 0; key_pat[0] = 4'b0011; key_on[0] = 1'b1;
        clocks(4);  chk("multi_row_adv1", 32'(rd[0]), 32'h2);
        clocks(4);  chk("multi_row_adv2", 32'(rd[0]), 32'h4);
        chk("multi_no_held", 32'(kh[0]), 32'h0);
        key_on[0] = 1'b0;

        // Bounce: two matching ticks then gone
        wait_row(0, 4'b0100);
        key_row[0] = 2; key_pat[0] = 4'b0010; key_on[0] = 1'b1;
        clocks(8);
        chk("bounce_row_held", 32'(rd[0]), 32'h4);
        key_on[0] = 1'b0;
        clocks(4);
        chk("bounce_next_row", 32'(rd[0]), 32'h8);
        chk("bounce_no_held", 32'(kh[0]), 32'h0);

        // Press row 2 / col 1 -> code 9, then release
        wait_row(0, 4'b0100);
        exp_q0.push_back(9);
        key_on[0] = 1'b1;
        clocks(12);
        chk("press_valid", 32'(kv[0]), 32'h1);
        chk("press_code", 32'(kc[0]), 32'h9);
        chk("press_held", 32'(kh[0]), 32'h1);
        clocks(20);
        chk("press_row_frozen", 32'(rd[0]), 32'h4);
        chk("press_still_held", 32'(kh[0]), 32'h1);
        key_on[0] = 1'b0;
        wait_release(0);
        chk("release_held_low", 32'(kh[0]), 32'h0);
        chk("release_next_row", 32'(rd[0]), 32'h8);
        chk("release_code_kept", 32'(kc[0]), 32'h9);

        // Auto-repeat on key 3 with a one-tick release glitch mid-hold
        wait_row(1, 4'b0001);
        repeat (4) exp_q1.push_back(3);
        key_row[1] = 0; key_pat[1] = 4'b1000; key_on[1] = 1'b1;
        clocks(12);
        chk("rep_accept", 32'(kv[1]), 32'h1);
        clocks(20);
        chk("rep_first", 32'(kv[1]), 32'h1);
        key_on[1] = 1'b0;
        clocks(4);
        key_on[1] = 1'b1;
        clocks(20);
        chk("rep_glitch_delay", 32'(kv[1]), 32'h0);
        chk("rep_glitch_held", 32'(kh[1]), 32'h1);
        chk("rep_glitch_no_release", 32'(rel_cnt[1]), 32'd0);
        clocks(4);
        chk("rep_after_glitch", 32'(kv[1]), 32'h1);
        chk("rep_code", 32'(kc[1]), 32'h3);
        clocks(20);
        chk("rep_last", 32'(kv[1]), 32'h1);
        key_on[1] = 1'b0;
        wait_release(1);
        chk("rep_release_held", 32'(kh[1]), 32'h0);

        // Active-low press row 2 / col 1, then reset while held
        wait_row(2, 4'b1011);
        exp_q2.push_back(9);
        key_row[2] = 2; key_pat[2] = 4'b0010; key_on[2] = 1'b1;
        clocks(12);
        chk("al_code", 32'(kc[2]), 32'h9);
        chk("al_held", 32'(kh[2]), 32'h1);
        clocks(8);
        chk("al_row_frozen", 32'(rd[2]), 32'hb);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midreset_row_l", 32'(rd[2]), 32'he);
        chk("midreset_held_l", 32'(kh[2]), 32'h0);
        chk("midreset_code_l", 32'(kc[2]), 32'h0);
        chk("midreset_row_a", 32'(rd[0]), 32'h1);
        reset = 1'b0;
        key_on[2] = 1'b0;
        clocks(40);
        chk("al_post_reset_scan_idle", 32'(kh[2]), 32'h0);

        chk("sb_empty_a", 32'(exp_q0.size()), 32'd0);
        chk("sb_empty_r", 32'(exp_q1.size()), 32'd0);
        chk("sb_empty_l", 32'(exp_q2.size()), 32'd0);
        chk("release_count_a", 32'(rel_cnt[0]), 32'd1);
        chk("release_count_r", 32'(rel_cnt[1]), 32'd1);
        chk("release_count_l", 32'(rel_cnt[2]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
